// File: rtl/rob_commit_buffer.sv
// Reorder buffer: in-order allocate, out-of-order complete, in-order single-slot retire with flush.
// Define ROB_SAME_CYCLE_COMMIT_EN to let a completion at the head retire in the same cycle.
module rob_commit_buffer #(
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned IDX_W      = $clog2(ENTRIES),
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [4:0]       alloc_rd,
  input  logic [31:0]      alloc_pc,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             ex_valid,
  input  logic [IDX_W-1:0] entry_index,
  input  logic [31:0]      ex_val,
  input  logic             br_mispred,
  input  logic             exception,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic [31:0]      commit_pc,
  output logic             flush,
  output logic [31:0]      flush_pc,
  output logic             rob_empty
);

  localparam logic [IDX_W:0] FullCount = (IDX_W+1)'(ENTRIES);

  logic [ENTRIES-1:0] valid_q, done_q, mispred_q, exc_q;
  logic [4:0]         rd_q  [ENTRIES];
  logic [31:0]        pc_q  [ENTRIES];
  logic [31:0]        val_q [ENTRIES];
  logic [IDX_W-1:0]   head_q, tail_q;
  logic [IDX_W:0]     count_q;

  logic        head_done, head_mp, head_exc, retire_ok;
  logic [31:0] head_val;
  logic        alloc_fire, cmpl_fire;

`ifdef ROB_SAME_CYCLE_COMMIT_EN
  logic head_hit;
  // A live completion of the not-yet-done head overrides the stored slot state.
  assign head_hit  = ex_valid && (entry_index == head_q) && valid_q[head_q] && !done_q[head_q];
  assign head_done = done_q[head_q] || head_hit;
  assign head_val  = head_hit ? ex_val     : val_q[head_q];
  assign head_mp   = head_hit ? br_mispred : mispred_q[head_q];
  assign head_exc  = head_hit ? exception  : exc_q[head_q];
`else
  assign head_done = done_q[head_q];
  assign head_val  = val_q[head_q];
  assign head_mp   = mispred_q[head_q];
  assign head_exc  = exc_q[head_q];
`endif

  always_comb begin
    retire_ok    = rst_n && valid_q[head_q] && head_done;
    commit_valid = retire_ok && !head_exc;
    flush        = retire_ok && (head_exc || head_mp);
    flush_pc     = 32'h0;
    if (flush) flush_pc = head_exc ? EXC_VECTOR : head_val;
    commit_rd    = rd_q[head_q];
    commit_pc    = pc_q[head_q];
    commit_val   = head_val;
    alloc_ready  = (count_q != FullCount) && !flush;
    alloc_idx    = tail_q;
    rob_empty    = (count_q == '0);
    alloc_fire   = alloc_valid && alloc_ready;
    cmpl_fire    = ex_valid && valid_q[entry_index] && !done_q[entry_index] && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      // Everything younger than the head is wrong-path; restart just past the head.
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= head_q + IDX_W'(1);
      tail_q  <= head_q + IDX_W'(1);
      count_q <= '0;
    end else begin
      if (cmpl_fire) done_q[entry_index] <= 1'b1;
      if (commit_valid) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + IDX_W'(1);
      end
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        tail_q          <= tail_q + IDX_W'(1);
      end
      count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_valid);
    end
  end

  // Payload needs no reset: it is only observed through valid/done.
  always_ff @(posedge clk) begin
    if (cmpl_fire) begin
      val_q[entry_index]     <= ex_val;
      mispred_q[entry_index] <= br_mispred;
      exc_q[entry_index]     <= exception;
    end
    if (alloc_fire) begin
      rd_q[tail_q] <= alloc_rd;
      pc_q[tail_q] <= alloc_pc;
    end
  end

endmodule

// File: tb/tb_rob_commit_buffer.sv
// Scoreboard bench for rob_commit_buffer: directed stimulus pushes expected retire/flush events,
// a negedge monitor pops and compares them whenever the DUT commits or flushes.
module tb_rob_commit_buffer;

  logic        clk, rst_n;
  logic        alloc_valid, alloc_ready;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc;
  logic [2:0]  alloc_idx;
  logic        ex_valid;
  logic [2:0]  entry_index;
  logic [31:0] ex_val;
  logic        br_mispred, exception;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val, commit_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        rob_empty;

  rob_commit_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_idx(alloc_idx),
    .ex_valid(ex_valid), .entry_index(entry_index), .ex_val(ex_val),
    .br_mispred(br_mispred), .exception(exception),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_pc(commit_pc), .flush(flush), .flush_pc(flush_pc), .rob_empty(rob_empty)
  );

  typedef struct {
    logic        cv;
    logic        fl;
    logic [31:0] fpc;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every commit or flush must match the oldest expected event.
  always @(negedge clk) begin
    if (commit_valid || flush) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", {30'h0, commit_valid, flush}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_valid", {31'h0, commit_valid}, {31'h0, e.cv});
        check("flush", {31'h0, flush}, {31'h0, e.fl});
        check("flush_pc", flush_pc, e.fpc);
        if (e.cv) begin
          check("commit_rd", {27'h0, commit_rd}, {27'h0, e.rd});
          check("commit_val", commit_val, e.val);
          check("commit_pc", commit_pc, e.pc);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [31:0] pc, input logic [2:0] exp_idx);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    alloc_pc    = pc;
    check("alloc_ready", {31'h0, alloc_ready}, 32'h1);
    check("alloc_idx", {29'h0, alloc_idx}, {29'h0, exp_idx});
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic drive_cmpl(input logic [2:0] idx, input logic [31:0] v, input logic mp,
                            input logic ex);
    ex_valid    = 1'b1;
    entry_index = idx;
    ex_val      = v;
    br_mispred  = mp;
    exception   = ex;
  endtask

  task automatic clear_cmpl;
    ex_valid   = 1'b0;
    br_mispred = 1'b0;
    exception  = 1'b0;
  endtask

  task automatic complete(input logic [2:0] idx, input logic [31:0] v, input logic mp,
                          input logic ex);
    drive_cmpl(idx, v, mp, ex);
    tick();
    clear_cmpl();
  endtask

  function automatic exp_t mk(input logic cv, input logic fl, input logic [31:0] fpc,
                              input logic [4:0] rd, input logic [31:0] val,
                              input logic [31:0] pc);
    exp_t e;
    e.cv = cv; e.fl = fl; e.fpc = fpc; e.rd = rd; e.val = val; e.pc = pc;
    return e;
  endfunction

  initial begin
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0;
    ex_valid = 1'b0; entry_index = '0; ex_val = '0; br_mispred = 1'b0; exception = 1'b0;

    // Reset state
    do_reset();
    check("rst_alloc_ready", {31'h0, alloc_ready}, 32'h1);
    check("rst_alloc_idx", {29'h0, alloc_idx}, 32'h0);
    check("rst_commit_valid", {31'h0, commit_valid}, 32'h0);
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_flush_pc", flush_pc, 32'h0);
    check("rst_rob_empty", {31'h0, rob_empty}, 32'h1);

    // Single allocate / complete / commit
    alloc(5'd5, 32'h40, 3'd0);
    check("t1_not_empty", {31'h0, rob_empty}, 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 32'h0, 5'd5, 32'h1234, 32'h40));
    complete(3'd0, 32'h1234, 1'b0, 1'b0);
    tick();
    check("t1_empty_after", {31'h0, rob_empty}, 32'h1);

    // Fill to capacity, hold off the 9th, free one slot, wrap tail
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1), 32'h100 + 32'(4 * i), 3'(i));
    check("full_not_ready", {31'h0, alloc_ready}, 32'h0);
    alloc_valid = 1'b1; alloc_rd = 5'd31; alloc_pc = 32'hdead;
    tick();
    alloc_valid = 1'b0;
    check("full_held_off", {31'h0, alloc_ready}, 32'h0);
    check("full_idx_wrapped", {29'h0, alloc_idx}, 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 32'h0, 5'd1, 32'ha0, 32'h100));
`ifdef ROB_SAME_CYCLE_COMMIT_EN
    drive_cmpl(3'd0, 32'ha0, 1'b0, 1'b0);
    #1;
    check("full_commit_cycle_ready", {31'h0, alloc_ready}, 32'h0);
    tick();
    clear_cmpl();
`else
    complete(3'd0, 32'ha0, 1'b0, 1'b0);
    check("full_commit_cycle_ready", {31'h0, alloc_ready}, 32'h0);
    tick();
`endif
    check("full_freed_ready", {31'h0, alloc_ready}, 32'h1);
    alloc(5'd9, 32'h200, 3'd0);
    check("full_again", {31'h0, alloc_ready}, 32'h0);

    // Out-of-order completion, in-order retirement
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(10 + i), 32'h300 + 32'(4 * i), 3'(i));
    for (int i = 3; i >= 1; i--) complete(3'(i), 32'h30 + 32'(i), 1'b0, 1'b0);
    check("ooo_no_commit_yet", {31'h0, rob_empty}, 32'h0);
    for (int i = 0; i < 4; i++) sb.push_back(mk(1'b1, 1'b0, 32'h0, 5'(10 + i), 32'h30 + 32'(i),
                                                  32'h300 + 32'(4 * i)));
    complete(3'd0, 32'h30, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("ooo_drained", {31'h0, rob_empty}, 32'h1);

    // Mispredict at head
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(20 + i), 32'h400 + 32'(4 * i), 3'(i));
    sb.push_back(mk(1'b1, 1'b1, 32'h200, 5'd20, 32'h200, 32'h400));
`ifdef ROB_SAME_CYCLE_COMMIT_EN
    drive_cmpl(3'd0, 32'h200, 1'b1, 1'b0);
    #1;
    check("mp_flush_blocks_alloc", {31'h0, alloc_ready}, 32'h0);
    tick();
    clear_cmpl();
`else
    complete(3'd0, 32'h200, 1'b1, 1'b0);
    check("mp_flush_blocks_alloc", {31'h0, alloc_ready}, 32'h0);
    tick();
`endif
    check("mp_empty", {31'h0, rob_empty}, 32'h1);
    check("mp_tail_is_1", {29'h0, alloc_idx}, 32'h1);

    // Exception at head (mispred also set: exception wins), concurrent alloc refused
    do_reset();
    alloc(5'd1, 32'h500, 3'd0);
    alloc(5'd2, 32'h504, 3'd1);
    sb.push_back(mk(1'b0, 1'b1, 32'h100, 5'd0, 32'h0, 32'h0));
`ifdef ROB_SAME_CYCLE_COMMIT_EN
    drive_cmpl(3'd0, 32'h999, 1'b1, 1'b1);
    alloc_valid = 1'b1;
    #1;
    check("exc_alloc_blocked", {31'h0, alloc_ready}, 32'h0);
    tick();
    clear_cmpl();
    alloc_valid = 1'b0;
`else
    complete(3'd0, 32'h999, 1'b1, 1'b1);
    alloc_valid = 1'b1;
    check("exc_alloc_blocked", {31'h0, alloc_ready}, 32'h0);
    tick();
    alloc_valid = 1'b0;
`endif
    check("exc_empty", {31'h0, rob_empty}, 32'h1);
    check("exc_tail_is_1", {29'h0, alloc_idx}, 32'h1);

    // Reset mid-operation, with a head completion racing the reset edge
    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 1), 32'h600 + 32'(4 * i), 3'(i));
    complete(3'd2, 32'h22, 1'b0, 1'b0);
    drive_cmpl(3'd0, 32'h11, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    clear_cmpl();
    check("mid_rst_empty", {31'h0, rob_empty}, 32'h1);
    check("mid_rst_idx", {29'h0, alloc_idx}, 32'h0);
    check("mid_rst_no_commit", {31'h0, commit_valid}, 32'h0);
    check("mid_rst_no_flush", {31'h0, flush}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_still_empty", {31'h0, rob_empty}, 32'h1);

    // Completion-to-commit latency at the head
    do_reset();
    alloc(5'd7, 32'h80, 3'd0);
    sb.push_back(mk(1'b1, 1'b0, 32'h0, 5'd7, 32'h77, 32'h80));
    drive_cmpl(3'd0, 32'h77, 1'b0, 1'b0);
    #1;
`ifdef ROB_SAME_CYCLE_COMMIT_EN
    check("same_cycle_commit", {31'h0, commit_valid}, 32'h1);
`else
    check("no_same_cycle_commit", {31'h0, commit_valid}, 32'h0);
`endif
    tick();
    clear_cmpl();
    tick();
    check("lat_empty", {31'h0, rob_empty}, 32'h1);

    tick();
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
